sample_capture_buffer: RTL and testbench

SAMPLE_CAPTURE_BUFFER -- requirements
Module: sample_capture_buffer

---
 rtl/sample_capture_buffer.sv | 158 +++++++++++++++
 tb/tb_sample_capture_buffer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sample_capture_buffer.sv
// Multi-channel sample capture buffer: strobed sampling into a tagged FIFO.
// Ports: clk/reset, ch_data, arm/stop/mode, threshold, clear_ovf,
//        rd_req -> rd_data/rd_chan/rd_valid, status flags, level, state.
module sample_capture_buffer #(
    parameter int DATA_W = 16,
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 512,
    parameter int DIV    = 50,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic                     arm,
    input  logic                     stop,
    input  logic                     mode,
    input  logic [AW:0]              threshold,
    input  logic                     clear_ovf,
    input  logic                     rd_req,
    output logic [DATA_W-1:0]        rd_data,
    output logic [CW-1:0]            rd_chan,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     data_ready,
    output logic                     overflow,
    output logic                     done,
    output logic [AW:0]              level,
    output logic [1:0]               state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam int DVW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [DVW-1:0] DIV_LAST = DVW'(DIV - 1);
    localparam logic [CW-1:0]  CH_LAST  = CW'(NUM_CH - 1);

    logic [DVW-1:0]           div_cnt;
    logic [CW-1:0]            seq_ch;
    logic                     seq_act;
    logic                     mode_q;
    logic [NUM_CH*DATA_W-1:0] lat;
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic [CW+DATA_W-1:0]     mem [DEPTH];

    logic strobe;
    logic wr_en;
    logic rd_allow;
    logic pop;
    logic wr_ok;
    logic ovf_set;
    logic [CW+DATA_W-1:0] wr_word;

    assign full       = (level == (AW+1)'(DEPTH));
    assign empty      = (level == '0);
    assign data_ready = (level >= threshold) && (threshold != '0);

    assign strobe   = (state == S_FILL) && (div_cnt == DIV_LAST);
    assign wr_en    = (state == S_FILL) && seq_act;
    // DRAIN only happens in one-shot; otherwise continuous mode reads anywhere
    assign rd_allow = (state == S_DRAIN) || mode_q;
    assign pop      = rd_req && !empty && rd_allow;
    // a simultaneous pop frees the slot the write would otherwise lack
    assign wr_ok    = wr_en && (!full || pop);
    assign ovf_set  = wr_en && full && !pop;
    assign wr_word  = {seq_ch, lat[int'(seq_ch)*DATA_W +: DATA_W]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            mode_q  <= 1'b0;
            div_cnt <= '0;
            seq_ch  <= '0;
            seq_act <= 1'b0;
            lat     <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (arm) begin
                        state   <= S_FILL;
                        mode_q  <= mode;
                        div_cnt <= '0;
                        seq_act <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (!mode_q && full) begin
                        state   <= S_DRAIN;
                        seq_act <= 1'b0;
                    end else if (mode_q && stop) begin
                        state   <= S_IDLE;
                        seq_act <= 1'b0;
                    end else begin
                        div_cnt <= strobe ? '0 : div_cnt + 1'b1;
                        if (strobe) begin
                            lat     <= ch_data;
                            seq_act <= 1'b1;
                            seq_ch  <= '0;
                        end else if (seq_act) begin
                            if (seq_ch == CH_LAST)
                                seq_act <= 1'b0;
                            else
                                seq_ch <= seq_ch + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (empty) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_chan  <= '0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (wr_ok && !pop)
                level <= level + 1'b1;
            else if (pop && !wr_ok)
                level <= level - 1'b1;
            // a new overflow wins over a clear in the same cycle
            if (ovf_set)
                overflow <= 1'b1;
            else if (clear_ovf)
                overflow <= 1'b0;
            rd_valid <= pop;
            if (pop)
                {rd_chan, rd_data} <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= wr_word;
    end

endmodule

// File: tb/tb_sample_capture_buffer.sv
// Directed bench for sample_capture_buffer (DATA_W=16, NUM_CH=2, DEPTH=8, DIV=4).
// Ports: drives every DUT input, checks outputs #1 after each rising edge.
module tb_sample_capture_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ch_data;
    logic        arm, stop, mode, clear_ovf, rd_req;
    logic [3:0]  threshold;
    logic [15:0] rd_data;
    logic [0:0]  rd_chan;
    logic        rd_valid, full, empty, data_ready, overflow, done;
    logic [3:0]  level;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    sample_capture_buffer #(
        .DATA_W(16), .NUM_CH(2), .DEPTH(8), .DIV(4)
    ) dut (
        .clk(clk), .reset(reset), .ch_data(ch_data), .arm(arm),
        .stop(stop), .mode(mode), .threshold(threshold),
        .clear_ovf(clear_ovf), .rd_req(rd_req), .rd_data(rd_data),
        .rd_chan(rd_chan), .rd_valid(rd_valid), .full(full),
        .empty(empty), .data_ready(data_ready), .overflow(overflow),
        .done(done), .level(level), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // value presented before edge c after arm; latched on edges 4,8,12,...
    function automatic logic [31:0] chd(input int c);
        logic [15:0] n;
        n = 16'((c + 3) / 4);
        return {16'hB000 | n, 16'hA000 | n};
    endfunction

    // writes land on edges 5,6,9,10,13,14,17,18 after arm
    function automatic int lvl_exp(input int c);
        int k;
        k = 0;
        for (int e = 5; e <= c && e <= 18; e++)
            if ((e % 4 == 1) || (e % 4 == 2)) k++;
        return k;
    endfunction

    logic [15:0] exp_d [8];

    initial begin
        reset = 1'b1; ch_data = '0; arm = 0; stop = 0; mode = 0;
        clear_ovf = 0; rd_req = 0; threshold = 4'd0;
        tick(); tick();
        chk("rst_state", 32'(state), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_level", 32'(level), 0);
        chk("rst_valid", 32'(rd_valid), 0);
        chk("rst_dready", 32'(data_ready), 0);
        reset = 1'b0;
        tick();

        // one-shot fill with stray rd_req, arm and stop during FILL
        mode = 0; arm = 1;
        tick();
        arm = 0;
        chk("os_enter", 32'(state), 1);
        for (int c = 1; c <= 19; c++) begin
            ch_data = chd(c);
            rd_req = (c == 2);
            arm = (c == 3);
            stop = (c == 7);
            tick();
            rd_req = 0; arm = 0; stop = 0;
            chk("os_level", 32'(level), 32'(lvl_exp(c)));
            chk("os_state", 32'(state), (c < 19) ? 1 : 2);
            chk("os_noread", 32'(rd_valid), 0);
        end
        chk("os_full", 32'(full), 1);

        // one-shot drain
        rd_req = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("dr_valid", 32'(rd_valid), 1);
            chk("dr_data", 32'(rd_data),
                32'(((i % 2) ? 16'hB000 : 16'hA000) | 16'(i / 2 + 1)));
            chk("dr_chan", 32'(rd_chan), 32'(i % 2));
        end
        tick();
        chk("dr_end_valid", 32'(rd_valid), 0);
        chk("dr_done", 32'(done), 1);
        chk("dr_state", 32'(state), 0);
        chk("dr_empty", 32'(empty), 1);
        rd_req = 0;
        tick();
        chk("dr_done_pulse", 32'(done), 0);

        // continuous: threshold, overflow, clear, write+pop at full
        threshold = 4'd4; mode = 1; arm = 1;
        tick();
        arm = 0;
        for (int c = 1; c <= 26; c++) begin
            ch_data = chd(c);
            clear_ovf = (c == 23);
            rd_req = (c == 25) || (c == 26);
            tick();
            clear_ovf = 0; rd_req = 0;
            if (c == 9) chk("ct_dready_lo", 32'(data_ready), 0);
            if (c == 10) begin
                chk("ct_dready_hi", 32'(data_ready), 1);
                chk("ct_level4", 32'(level), 4);
            end
            if (c == 18) chk("ct_full", 32'(full), 1);
            if (c == 21) begin
                chk("ct_ovf_set", 32'(overflow), 1);
                chk("ct_ovf_level", 32'(level), 8);
            end
            if (c == 23) chk("ct_ovf_clr", 32'(overflow), 0);
            if (c == 25 || c == 26) begin
                chk("ct_wp_valid", 32'(rd_valid), 1);
                chk("ct_wp_data", 32'(rd_data),
                    (c == 25) ? 32'hA001 : 32'hB001);
                chk("ct_wp_chan", 32'(rd_chan), (c == 25) ? 0 : 1);
                chk("ct_wp_level", 32'(level), 8);
                chk("ct_wp_ovf", 32'(overflow), 0);
            end
            chk("ct_state", 32'(state), 1);
        end
        stop = 1;
        tick();
        stop = 0;
        chk("ct_stop", 32'(state), 0);

        exp_d[0] = 16'hA002; exp_d[1] = 16'hB002;
        exp_d[2] = 16'hA003; exp_d[3] = 16'hB003;
        exp_d[4] = 16'hA004; exp_d[5] = 16'hB004;
        exp_d[6] = 16'hA006; exp_d[7] = 16'hB006;
        rd_req = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("id_valid", 32'(rd_valid), 1);
            chk("id_data", 32'(rd_data), 32'(exp_d[i]));
            chk("id_chan", 32'(rd_chan), 32'(i % 2));
        end
        rd_req = 0;
        tick();
        chk("id_empty", 32'(empty), 1);
        chk("id_novalid", 32'(rd_valid), 0);
        chk("id_hold", 32'(rd_data), 32'hB006);

        // reset in DRAIN with level 5
        mode = 0; arm = 1;
        tick();
        arm = 0;
        for (int c = 1; c <= 19; c++) begin
            ch_data = chd(c);
            tick();
        end
        chk("rs_drain", 32'(state), 2);
        rd_req = 1;
        tick(); tick(); tick();
        rd_req = 0;
        chk("rs_level5", 32'(level), 5);
        chk("rs_pre_data", 32'(rd_data), 32'hA002);
        #1;
        reset = 1'b1;
        #1;
        chk("ar_state", 32'(state), 0);
        chk("ar_level", 32'(level), 0);
        chk("ar_empty", 32'(empty), 1);
        chk("ar_full", 32'(full), 0);
        chk("ar_dready", 32'(data_ready), 0);
        chk("ar_valid", 32'(rd_valid), 0);
        chk("ar_data", 32'(rd_data), 0);
        chk("ar_chan", 32'(rd_chan), 0);
        chk("ar_done", 32'(done), 0);
        chk("ar_ovf", 32'(overflow), 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        arm = 1;
        tick();
        arm = 0;
        chk("ra_state", 32'(state), 1);
        chk("ra_empty", 32'(empty), 1);
        for (int c = 1; c <= 5; c++) begin
            ch_data = chd(c);
            tick();
        end
        chk("ra_level1", 32'(level), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
